// File: rtl/approx_mult_stream.sv
// approx_mult_stream: pipelined valid/ready approximate multiplier with per-frame error statistics
module approx_mult_stream #(
    parameter int WIDTH     = 8,
    parameter int APPROX_K  = 8,
    parameter int FRAME_LEN = 65536,
    parameter int CNT_W     = 16,
    parameter int ERR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [2*WIDTH-1:0]   out_err,
    input  logic                 clear,
    output logic [CNT_W-1:0]     pix_count,
    output logic                 frame_done,
    output logic [ERR_W-1:0]     err_frame
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = (ERR_W > PW ? ERR_W : PW) + 1;
    localparam logic [PW-1:0]    LOW_MASK = {PW{1'b1}} >> (PW - APPROX_K);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [ERR_W-1:0] SUM_MAX  = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [PW-1:0]    p_q, p_d, err_q, err_d;
    logic [CNT_W-1:0] pix_count_q, pix_count_d;
    logic [ERR_W-1:0] err_sum_q, err_sum_d, err_frame_q, err_frame_d, sum_sat;
    logic             frame_done_q, frame_done_d;
    logic [PW-1:0]    pp, exact, hi, lo, mode_p;
    logic [SW-1:0]    sum_add;
    logic             s1_load, s2_load, in_fire, out_fire, last;

    // Partial products split at column APPROX_K: high parts summed exactly, low parts ORed.
    always_comb begin
        pp    = '0;
        exact = '0;
        hi    = '0;
        lo    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp    = b_q[i] ? PW'(a_q) << i : '0;
            exact = exact + pp;
            hi    = hi + (pp >> APPROX_K);
            lo    = lo | (pp & LOW_MASK);
        end
        mode_p = mode_q == 2'd1 ? (hi << APPROX_K) | lo :
                 mode_q == 2'd2 ? hi << APPROX_K : exact;
    end

    // Handshake and pipeline advance: each stage loads when empty or when its content moves on.
    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_load    = !s1_valid_q || s2_load;
        in_ready   = s1_load;
        in_fire    = in_valid && s1_load;
        out_fire   = s2_valid_q && out_ready;
        s1_valid_d = s1_load ? in_valid : s1_valid_q;
        a_d        = in_fire ? in_a : a_q;
        b_d        = in_fire ? in_b : b_q;
        mode_d     = in_fire ? in_mode : mode_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        p_d        = (s2_load && s1_valid_q) ? mode_p : p_q;
        err_d      = (s2_load && s1_valid_q) ? exact - mode_p : err_q;
    end

    // Frame statistics: clear overrides a coincident transfer and never completes a frame.
    always_comb begin
        sum_add      = SW'(err_sum_q) + SW'(err_q);
        sum_sat      = sum_add > SW'(SUM_MAX) ? SUM_MAX : sum_add[ERR_W-1:0];
        last         = pix_count_q == LAST_CNT;
        pix_count_d  = clear ? '0 : !out_fire ? pix_count_q : last ? '0 : pix_count_q + CNT_W'(1);
        err_sum_d    = clear ? '0 : !out_fire ? err_sum_q : last ? '0 : sum_sat;
        frame_done_d = !clear && out_fire && last;
        err_frame_d  = frame_done_d ? sum_sat : err_frame_q;
    end

    // State registers with synchronous active-low reset dropping all in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            s2_valid_q   <= 1'b0;
            p_q          <= '0;
            err_q        <= '0;
            pix_count_q  <= '0;
            err_sum_q    <= '0;
            err_frame_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            s2_valid_q   <= s2_valid_d;
            p_q          <= p_d;
            err_q        <= err_d;
            pix_count_q  <= pix_count_d;
            err_sum_q    <= err_sum_d;
            err_frame_q  <= err_frame_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_p      = p_q;
    assign out_err    = err_q;
    assign pix_count  = pix_count_q;
    assign frame_done = frame_done_q;
    assign err_frame  = err_frame_q;
endmodule

// File: tb/tb_approx_mult_stream.sv
// tb_approx_mult_stream: randomized and directed checks of approx_mult_stream against a behavioural model
module tb_approx_mult_stream;
    localparam int W  = 8;
    localparam int K  = 8;
    localparam int FL = 4;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clear = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [1:0]  in_mode = '0;
    logic        in_ready, out_valid, frame_done;
    logic [15:0] out_p, out_err, pix_count;
    logic [31:0] err_frame;
    logic        s_in_ready, s_out_valid, s_frame_done;
    logic [15:0] s_out_p, s_out_err, s_pix_count;
    logic [11:0] s_err_frame;

    always #5 clk = ~clk;

    approx_mult_stream #(.WIDTH(W), .APPROX_K(K), .FRAME_LEN(FL), .CNT_W(16), .ERR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err),
        .clear(clear), .pix_count(pix_count), .frame_done(frame_done), .err_frame(err_frame));

    approx_mult_stream #(.WIDTH(W), .APPROX_K(K), .FRAME_LEN(FL), .CNT_W(16), .ERR_W(12)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(s_out_valid), .out_ready(out_ready), .out_p(s_out_p), .out_err(s_out_err),
        .clear(clear), .pix_count(s_pix_count), .frame_done(s_frame_done), .err_frame(s_err_frame));

    typedef struct { int p; int e; } res_t;
    res_t   pend_q[$], exp_q[$], obs_q[$];
    int     vectors = 0, miscompares = 0;
    int     m_cnt;
    longint m_s32, m_s12, m_f32, m_f12;
    bit     m_fd;

    function automatic res_t model(int a, int b, int m);
        res_t r;
        int exact, h, l, pp, pk;
        pk    = 1 << K;
        exact = a * b;
        h     = 0;
        l     = 0;
        for (int i = 0; i < W; i++)
            if (((b >> i) & 1) != 0) begin
                pp = a * (1 << i);
                h += pp / pk;
                l |= pp % pk;
            end
        r.p = (m == 1) ? h * pk + l : (m == 2) ? h * pk : exact;
        r.e = exact - r.p;
        return r;
    endfunction

    task automatic model_reset();
        pend_q.delete(); exp_q.delete(); obs_q.delete();
        m_cnt = 0; m_s32 = 0; m_s12 = 0; m_f32 = 0; m_f12 = 0; m_fd = 0;
    endtask

    task automatic step(input bit v, input int a, input int b, input int m, input bit ordy, input bit clr,
                        output bit rdy);
        res_t r, o;
        @(negedge clk);
        in_valid = v; in_a = 8'(a); in_b = 8'(b); in_mode = 2'(m); out_ready = ordy; clear = clr;
        #1;
        rdy  = in_ready;
        m_fd = 0;
        r    = '{0, 0};
        if (v && in_ready) pend_q.push_back(model(a, b, m));
        if (out_valid && out_ready) begin
            if (pend_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL spurious_output: out_valid=1 with nothing outstanding, out_p=%0d", out_p);
            end else begin
                r   = pend_q.pop_front();
                o.p = int'(out_p);
                o.e = int'(out_err);
                exp_q.push_back(r);
                obs_q.push_back(o);
            end
            if (!clr) begin
                m_cnt++;
                m_s32 = (m_s32 + r.e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_s32 + r.e;
                m_s12 = (m_s12 + r.e > 4095) ? 4095 : m_s12 + r.e;
                if (m_cnt == FL) begin
                    m_f32 = m_s32; m_f12 = m_s12; m_cnt = 0; m_s32 = 0; m_s12 = 0; m_fd = 1;
                end
            end
        end
        if (clr) begin m_cnt = 0; m_s32 = 0; m_s12 = 0; end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit r;
        int n = 0;
        while (pend_q.size() > 0 && n < 20) begin
            step(0, 0, 0, 0, 1, 0, r);
            n++;
        end
        vectors++;
        if (pend_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", pend_q.size());
            pend_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; in_valid = 0; out_ready = 0; clear = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 0 || out_p !== 0 || out_err !== 0 || pix_count !== 0 || frame_done !== 0 ||
            err_frame !== 0 || in_ready !== 1) begin
            miscompares++;
            $display("FAIL reset_state: v=%b p=%0d e=%0d cnt=%0d fd=%b ef=%0d rdy=%b, required 0 0 0 0 0 0 1",
                     out_valid, out_p, out_err, pix_count, frame_done, err_frame, in_ready);
        end
        vectors++;
        if (s_out_valid !== 0 || s_out_p !== 0 || s_out_err !== 0 || s_pix_count !== 0 || s_frame_done !== 0 ||
            s_err_frame !== 0 || s_in_ready !== 1) begin
            miscompares++;
            $display("FAIL reset_state_sat: v=%b p=%0d e=%0d cnt=%0d fd=%b ef=%0d rdy=%b", s_out_valid, s_out_p,
                     s_out_err, s_pix_count, s_frame_done, s_err_frame, s_in_ready);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_latency();
        bit r;
        step(1, 3, 5, 1, 1, 0, r);
        vectors++;
        if (r !== 1 || out_valid !== 0) begin
            miscompares++;
            $display("FAIL latency_edge1: accepted=%b out_valid=%b, required 1 0", r, out_valid);
        end
        step(0, 0, 0, 0, 1, 0, r);
        vectors++;
        if (out_valid !== 1 || out_p !== 15 || out_err !== 0) begin
            miscompares++;
            $display("FAIL latency_edge2: out_valid=%b p=%0d e=%0d, required 1 15 0", out_valid, out_p, out_err);
        end
        drain();
    endtask

    task automatic test_modes();
        bit r;
        int ep[4] = '{65025, 63487, 63232, 65025};
        int ee[4] = '{0, 1538, 1793, 0};
        exp_q.delete(); obs_q.delete();
        for (int m = 0; m < 4; m++) step(1, 255, 255, m, 1, 0, r);
        drain();
        vectors++;
        if (obs_q.size() != 4) begin
            miscompares++;
            $display("FAIL modes_count: got %0d results, required 4", obs_q.size());
        end
        for (int m = 0; m < 4 && m < obs_q.size(); m++) begin
            vectors++;
            if (obs_q[m].p != ep[m] || obs_q[m].e != ee[m]) begin
                miscompares++;
                $display("FAIL mode%0d: p=%0d e=%0d, required %0d %0d", m, obs_q[m].p, obs_q[m].e, ep[m], ee[m]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit r, ordy, hold, exp_rdy;
        int sent = 0, c = 1;
        logic [15:0] prev_p, prev_e;
        exp_q.delete(); obs_q.delete();
        while ((sent < 10 || pend_q.size() > 0) && c < 60) begin
            ordy    = !(c >= 3 && c <= 6);
            hold    = out_valid && !ordy;
            prev_p  = out_p;
            prev_e  = out_err;
            exp_rdy = pend_q.size() < 2 || ordy;
            step(sent < 10, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), ordy, 0, r);
            vectors++;
            if (r !== exp_rdy) begin
                miscompares++;
                $display("FAIL bp_in_ready: cycle %0d in_ready=%b, required %b", c, r, exp_rdy);
            end
            if (hold) begin
                vectors++;
                if (out_valid !== 1 || out_p !== prev_p || out_err !== prev_e) begin
                    miscompares++;
                    $display("FAIL bp_stable: cycle %0d v=%b p=%0d e=%0d, required 1 %0d %0d", c, out_valid, out_p,
                             out_err, prev_p, prev_e);
                end
            end
            if (sent < 10 && r) sent++;
            c++;
        end
        vectors++;
        if (obs_q.size() != 10 || exp_q.size() != 10) begin
            miscompares++;
            $display("FAIL bp_count: got %0d results, required 10", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_data[%0d]: p=%0d e=%0d, required %0d %0d", i, obs_q[i].p, obs_q[i].e,
                         exp_q[i].p, exp_q[i].e);
            end
        end
    endtask

    task automatic test_frame();
        bit r;
        step(0, 0, 0, 0, 1, 1, r);
        vectors++;
        if (pix_count !== 0) begin
            miscompares++;
            $display("FAIL frame_clear: pix_count=%0d, required 0", pix_count);
        end
        for (int c = 0; c < 7; c++) begin
            step(c < 4, 255, 255, 1, 1, 0, r);
            vectors++;
            if (frame_done !== (c == 5) || pix_count !== 16'(m_cnt)) begin
                miscompares++;
                $display("FAIL frame_step%0d: fd=%b cnt=%0d, required %b %0d", c, frame_done, pix_count, c == 5, m_cnt);
            end
            if (c == 5) begin
                vectors++;
                if (err_frame !== 6152 || s_err_frame !== 4095 || pix_count !== 0) begin
                    miscompares++;
                    $display("FAIL frame_end: err_frame=%0d sat=%0d cnt=%0d, required 6152 4095 0", err_frame,
                             s_err_frame, pix_count);
                end
            end
        end
        step(1, 255, 255, 1, 1, 0, r);
        drain();
        vectors++;
        if (pix_count !== 1 || frame_done !== 0) begin
            miscompares++;
            $display("FAIL frame_fifth: cnt=%0d fd=%b, required 1 0", pix_count, frame_done);
        end
    endtask

    task automatic test_clear();
        bit r;
        step(1, 255, 255, 1, 0, 0, r);
        step(0, 0, 0, 0, 0, 0, r);
        step(0, 0, 0, 0, 1, 1, r);
        vectors++;
        if (pix_count !== 0 || err_frame !== 6152 || s_err_frame !== 4095 || frame_done !== 0) begin
            miscompares++;
            $display("FAIL clear_transfer: cnt=%0d ef=%0d sat=%0d fd=%b, required 0 6152 4095 0", pix_count,
                     err_frame, s_err_frame, frame_done);
        end
        for (int i = 0; i < 4; i++) step(1, 200 + i, 100 + i, 0, 1, 0, r);
        drain();
        vectors++;
        if (err_frame !== 0 || s_err_frame !== 0 || frame_done !== 1) begin
            miscompares++;
            $display("FAIL clear_sum: ef=%0d sat=%0d fd=%b, required 0 0 1", err_frame, s_err_frame, frame_done);
        end
    endtask

    task automatic test_reset_mid();
        bit r;
        step(1, 17, 23, 0, 0, 0, r);
        step(1, 99, 201, 1, 0, 0, r);
        @(negedge clk);
        rst_n = 0; in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 1, 0, r);
            vectors++;
            if (out_valid !== 0 || pix_count !== 0 || err_frame !== 0) begin
                miscompares++;
                $display("FAIL reset_mid%0d: v=%b cnt=%0d ef=%0d, required 0 0 0", c, out_valid, pix_count, err_frame);
            end
        end
    endtask

    task automatic test_random();
        bit r, v, ordy, clr, exp_rdy;
        exp_q.delete(); obs_q.delete();
        for (int c = 0; c < 300; c++) begin
            v       = $urandom_range(0, 3) != 0;
            ordy    = $urandom_range(0, 3) != 0;
            clr     = $urandom_range(0, 49) == 0;
            exp_rdy = pend_q.size() < 2 || ordy;
            step(v, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), ordy, clr, r);
            vectors++;
            if (r !== exp_rdy || pix_count !== 16'(m_cnt) || frame_done !== m_fd || err_frame !== 32'(m_f32) ||
                s_err_frame !== 12'(m_f12)) begin
                miscompares++;
                $display("FAIL rand_stats%0d: rdy=%b cnt=%0d fd=%b ef=%0d sat=%0d, required %b %0d %b %0d %0d", c, r,
                         pix_count, frame_done, err_frame, s_err_frame, exp_rdy, m_cnt, m_fd, m_f32, m_f12);
            end
        end
        drain();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_data[%0d]: p=%0d e=%0d, required %0d %0d", i, obs_q[i].p, obs_q[i].e,
                         exp_q[i].p, exp_q[i].e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_modes();
        test_backpressure();
        test_frame();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
